uart_io: RTL and testbench

//  Memory-mapped UART peripheral on the cpu IO bus; consumes io_addr/io_dout/io_we/io_rd, drives io_din.
//  TX side: FIFO drained by an 8N1 serialiser. RX side: 8N1 deserialiser into a one-byte holding register.

---
 rtl/uart_io.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_io.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART: TX FIFO drained by a serialiser, RX deserialiser into a one-byte
// holding register. Register reads are combinational; side effects commit on the clock edge.
module uart_io #(
  parameter logic [7:0]  BASE_ADDR  = 8'h20,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

  // Address decode
  logic w_hit_txd, w_hit_txs, w_hit_rxd, w_hit_rxs;
  assign w_hit_txd = (io_addr == BASE_ADDR);
  assign w_hit_txs = (io_addr == BASE_ADDR + 8'h04);
  assign w_hit_rxd = (io_addr == BASE_ADDR + 8'h08);
  assign w_hit_rxs = (io_addr == BASE_ADDR + 8'h0C);

  // TX FIFO: pointers carry an extra wrap bit
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        w_empty, w_full, w_push, w_drop, w_pop;
  logic [7:0]  w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = io_we && w_hit_txd && !w_full;
  assign w_drop  = io_we && w_hit_txd && w_full;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= io_dout[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // TX serialiser
  tx_state_e     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_tx_out;
  logic          w_tx_tick, w_busy;

  assign w_tx_tick = (r_tx_cnt == BAUD_LAST);
  assign w_busy    = (r_tx_state != TxIdle);
  assign w_pop     = !w_empty &&
                     ((r_tx_state == TxIdle) || ((r_tx_state == TxStop) && w_tx_tick));
  assign uart_tx   = r_tx_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_out   <= 1'b1;
    end else begin
      case (r_tx_state)
        TxIdle: begin
          if (!w_empty) begin
            r_tx_shift <= w_head;
            r_tx_out   <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TxStart;
          end
        end
        TxStart: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_out   <= r_tx_shift[0];
            r_tx_state <= TxData;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TxData: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_out   <= 1'b1;
              r_tx_state <= TxStop;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_out   <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TxStop: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            // Chain straight into the next start bit when more data is queued
            if (!w_empty) begin
              r_tx_shift <= w_head;
              r_tx_out   <= 1'b0;
              r_tx_state <= TxStart;
            end else begin
              r_tx_state <= TxIdle;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= TxIdle;
      endcase
    end
  end

  // RX synchroniser
  logic r_rx_s1, r_rx_s2, r_rx_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX deserialiser
  rx_state_e     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          w_rx_tick, w_rx_done, w_deliver, w_ferr;

  assign w_rx_tick = (r_rx_cnt == BAUD_LAST);
  assign w_rx_done = (r_rx_state == RxStop) && w_rx_tick;
  assign w_deliver = w_rx_done && r_rx_s2;
  assign w_ferr    = w_rx_done && !r_rx_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RxIdle: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RxStart;
          end
        end
        RxStart: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? RxIdle : RxData;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RxData: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RxStop;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RxStop: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_s2 ? RxIdle : RxWait;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RxWait: begin
          if (r_rx_s2) r_rx_state <= RxIdle;
        end
        default: r_rx_state <= RxIdle;
      endcase
    end
  end

  // Status and holding registers; a same-cycle set beats a clear
  logic       r_rx_valid, r_overrun, r_frame_err, r_tx_drop;
  logic [7:0] r_rx_byte;
  logic       w_rx_pop;

  assign w_rx_pop = io_rd && w_hit_rxd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_valid  <= 1'b0;
      r_rx_byte   <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_drop   <= 1'b0;
    end else begin
      if (w_deliver) begin
        r_rx_valid <= 1'b1;
        r_rx_byte  <= r_rx_shift;
      end else if (w_rx_pop) begin
        r_rx_valid <= 1'b0;
      end

      if (w_deliver && r_rx_valid && !w_rx_pop)  r_overrun <= 1'b1;
      else if (io_we && w_hit_rxs && io_dout[1]) r_overrun <= 1'b0;

      if (w_ferr)                                r_frame_err <= 1'b1;
      else if (io_we && w_hit_rxs && io_dout[2]) r_frame_err <= 1'b0;

      if (w_drop)                                r_tx_drop <= 1'b1;
      else if (io_we && w_hit_txs && io_dout[3]) r_tx_drop <= 1'b0;
    end
  end

  always_comb begin
    io_din = '0;
    if (io_rd) begin
      if (w_hit_txs)      io_din = {28'b0, r_tx_drop, w_busy, w_empty, w_full};
      else if (w_hit_rxd) io_din = {23'b0, r_rx_valid, r_rx_byte};
      else if (w_hit_rxs) io_din = {29'b0, r_frame_err, r_overrun, r_rx_valid};
    end
  end

  logic w_unused;
  assign w_unused = ^io_dout[31:8];

endmodule

// File: tb/tb_uart_io.sv
// Scoreboard bench for uart_io: bus reads and serial TX frames are checked by monitors
// against expectations queued by the directed stimulus.
module tb_uart_io;

  localparam int unsigned CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we, io_rd;
  logic [31:0] io_din;
  logic        uart_rx, uart_tx;

  uart_io #(
    .BASE_ADDR (8'h20),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_addr(io_addr),
    .io_dout(io_dout),
    .io_we  (io_we),
    .io_rd  (io_rd),
    .io_din (io_din),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] val;
    string       name;
  } rd_t;

  rd_t        rd_q[$];
  logic [7:0] tx_q[$];
  int         starts[$];
  bit         tx_ignore = 1'b0;

  // Bus read monitor
  always @(negedge clk) begin
    rd_t e;
    if (io_rd) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got %h expected no read", io_din);
      end else begin
        e = rd_q.pop_front();
        chk(e.name, io_din, e.val);
      end
    end
  end

  // Serial TX monitor: samples near the middle of each bit
  initial begin
    logic [7:0] b;
    logic       st, sb;
    forever begin
      @(negedge clk);
      if (rstn && uart_tx === 1'b0) begin
        starts.push_back(cyc);
        repeat (2) @(negedge clk);
        st = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        sb = uart_tx;
        if (!tx_ignore) begin
          chk("tx_start_mid", {31'b0, st}, 32'h0);
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_frame: got %h expected no frame", b);
          end else begin
            chk("tx_byte", {24'b0, b}, {24'b0, tx_q.pop_front()});
          end
          chk("tx_stop", {31'b0, sb}, 32'h1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    @(posedge clk);
    #1;
    io_we   = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    rd_t e;
    e.val  = exp;
    e.name = name;
    rd_q.push_back(e);
    io_addr = a;
    io_rd   = 1'b1;
    @(posedge clk);
    #1;
    io_rd   = 1'b0;
  endtask

  task automatic rx_bit(input logic v);
    uart_rx = v;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    uart_rx = 1'b1;
    idle(8);
  endtask

  initial begin
    logic [9:0] fr;
    rstn    = 1'b0;
    io_addr = '0;
    io_dout = '0;
    io_we   = 1'b0;
    io_rd   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);

    // Reset state
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    io_addr = 8'h24;
    @(negedge clk);
    chk("din_zero_without_rd", io_din, 32'h0);
    align();
    bus_rd(8'h24, 32'h2, "rst_txstat");
    bus_rd(8'h28, 32'h0, "rst_rxdata");
    bus_rd(8'h2C, 32'h0, "rst_rxstat");
    bus_rd(8'h30, 32'h0, "unmapped_read");
    bus_rd(8'h20, 32'h0, "txdata_read");

    // Single byte, cycle-exact waveform
    tx_q.push_back(8'hA5);
    bus_wr(8'h20, 32'hA5);
    @(negedge clk);
    chk("tx_idle_before_start", {31'b0, uart_tx}, 32'h1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("a5_bit%0d", i), {31'b0, uart_tx}, {31'b0, fr[i/4]});
    end
    align();
    bus_rd(8'h24, 32'h2, "txstat_after_a5");
    idle(4);

    // Five bytes back-to-back: FIFO full once the first is popped
    starts.delete();
    for (int i = 1; i <= 5; i++) begin
      tx_q.push_back(8'(i));
      bus_wr(8'h20, 32'(i));
    end
    bus_rd(8'h24, 32'h5, "txstat_full_busy");
    idle(220);
    bus_rd(8'h24, 32'h2, "txstat_drained");
    chk("b2b_frame_count", 32'(starts.size()), 32'd5);
    for (int i = 1; i < starts.size(); i++)
      chk($sformatf("b2b_gap%0d", i), 32'(starts[i] - starts[i-1]), 32'd40);

    // Six bytes: the sixth is dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tx_q.push_back(8'(8'h10 + i));
      bus_wr(8'h20, 32'(32'h10 + i));
    end
    bus_rd(8'h24, 32'hD, "txstat_drop");
    bus_wr(8'h24, 32'h8);
    bus_rd(8'h24, 32'h5, "txstat_drop_cleared");
    idle(220);
    bus_rd(8'h24, 32'h2, "txstat_drained2");

    // RX single frame
    send_frame(8'h3C, 1'b1);
    bus_rd(8'h2C, 32'h1, "rxstat_valid");
    bus_rd(8'h28, 32'h13C, "rxdata_3c");
    bus_rd(8'h2C, 32'h0, "rxstat_popped");

    // Overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    bus_rd(8'h2C, 32'h3, "rxstat_overrun");
    bus_rd(8'h28, 32'h122, "rxdata_22");
    bus_rd(8'h2C, 32'h2, "rxstat_overrun_kept");
    bus_wr(8'h2C, 32'h2);
    bus_rd(8'h2C, 32'h0, "rxstat_overrun_cleared");

    // Framing error leaves the held byte alone
    send_frame(8'h55, 1'b1);
    send_frame(8'h66, 1'b0);
    bus_rd(8'h2C, 32'h5, "rxstat_frame_err");
    bus_rd(8'h28, 32'h155, "rxdata_after_ferr");
    bus_rd(8'h2C, 32'h4, "rxstat_ferr_kept");
    bus_wr(8'h2C, 32'h4);
    bus_rd(8'h2C, 32'h0, "rxstat_ferr_cleared");

    // Two-cycle glitch
    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(40);
    bus_rd(8'h2C, 32'h0, "glitch_rxstat");
    bus_rd(8'h28, 32'h055, "glitch_rxdata");

    // Reset in the middle of a TX frame
    tx_ignore = 1'b1;
    bus_wr(8'h20, 32'h5A);
    @(posedge clk);
    #2;
    chk("tx_low_before_rst", {31'b0, uart_tx}, 32'h0);
    rstn = 1'b0;
    #1;
    chk("tx_async_rst", {31'b0, uart_tx}, 32'h1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tx_ignore = 1'b0;
    align();
    bus_rd(8'h24, 32'h2, "txstat_after_rst");
    bus_rd(8'h28, 32'h0, "rxdata_after_rst");
    idle(60);
    chk("tx_idle_after_rst", {31'b0, uart_tx}, 32'h1);

    chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
